// File: rtl/lcd_nibble_reader.sv
// Performs one HD44780-style 4-bit read (RW=1) on the Spartan-3E LCD bus.
// Returns busy flag plus address counter (rs_sel=0) or one data byte (rs_sel=1).
module lcd_nibble_reader #(
   parameter int T_AS   = 2,
   parameter int T_PW   = 12,
   parameter int T_GAP  = 50,
   parameter int T_HOLD = 2,
   parameter int CW     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       rs_sel,
   input  logic [3:0] d_in,
   output logic       sf_e,
   output logic       e,
   output logic       rs,
   output logic       rw,
   output logic       data_oe,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       bf,
   output logic [6:0] ac
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      PULSE_H = 3'd2,
      GAP     = 3'd3,
      PULSE_L = 3'd4,
      HOLD    = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Each timed state is loaded with (T_x - 1) on entry and left when it reaches 0.
   localparam logic [CW-1:0] CNT_AS   = CW'(T_AS - 1);
   localparam logic [CW-1:0] CNT_PW   = CW'(T_PW - 1);
   localparam logic [CW-1:0] CNT_GAP  = CW'(T_GAP - 1);
   localparam logic [CW-1:0] CNT_HOLD = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          e_q, e_d;
   logic          rs_q, rs_d;
   logic          rw_q, rw_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          sf_e_q;
   logic          data_oe_q;
   logic          last_s;

   assign last_s = (cnt_q == CNT_ZERO);

   // Next-state and next-output logic; outputs change on the transition out of a state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      e_d       = e_q;
      rs_d      = rs_q;
      rw_d      = rw_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = SETUP;
               cnt_d   = CNT_AS;
               rs_d    = rs_sel;
               rw_d    = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (last_s) begin
               state_d = PULSE_H;
               cnt_d   = CNT_PW;
               e_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         PULSE_H: begin
            if (last_s) begin
               state_d        = GAP;
               cnt_d          = CNT_GAP;
               e_d            = 1'b0;
               rd_data_d[7:4] = d_in;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         GAP: begin
            if (last_s) begin
               state_d = PULSE_L;
               cnt_d   = CNT_PW;
               e_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         PULSE_L: begin
            if (last_s) begin
               state_d        = HOLD;
               cnt_d          = CNT_HOLD;
               e_d            = 1'b0;
               rd_data_d[3:0] = d_in;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         HOLD: begin
            if (last_s) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
            rw_d    = 1'b0;
            busy_d  = 1'b0;
            rs_d    = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            e_d     = 1'b0;
            rs_d    = 1'b0;
            rw_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= CNT_ZERO;
         e_q       <= 1'b0;
         rs_q      <= 1'b0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_data_q <= 8'h00;
         sf_e_q    <= 1'b1;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         e_q       <= e_d;
         rs_q      <= rs_d;
         rw_q      <= rw_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
         sf_e_q    <= 1'b1;
         data_oe_q <= 1'b0;
      end
   end

   assign sf_e    = sf_e_q;
   assign e       = e_q;
   assign rs      = rs_q;
   assign rw      = rw_q;
   assign data_oe = data_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_data = rd_data_q;
   assign bf      = rd_data_q[7];
   assign ac      = rd_data_q[6:0];

endmodule

// File: doc/lcd_nibble_reader.md
Name: lcd_nibble_reader

Overview:
- Read-side counterpart of the character-LCD write path: performs one HD44780-style 4-bit read transaction (RW=1) on the Spartan-3E starter-board LCD bus.
- Returns either the busy flag plus address counter (RS=0) or one DDRAM/CGRAM data byte (RS=1).
- Sits beside the LCD write sequencer. The top-level mux grants it the e/rs/rw/sf_e pins while its busy output is high. The FPGA stays off the data bus for the whole transaction.

Parameters:
- T_AS, 2: cycles RS/RW are stable before E rises (≥40 ns at 50 MHz).
- T_PW, 12: cycles E is held high per nibble (≥230 ns). The nibble is sampled on the last of these cycles.
- T_GAP, 50: cycles E is low between the upper and lower nibble (≥1 µs).
- T_HOLD, 2: cycles RW stays high after the final E fall.
- CW, 8: width of the internal phase counter. Must satisfy 2^CW > max(T_AS, T_PW, T_GAP, T_HOLD).

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  start a read. Sampled only in IDLE.
- rs_sel  in  1  0 = busy-flag/address read, 1 = data read. Latched when req is accepted.
- d_in  in  4  LCD data pins DB7..DB4 (d,c,b,a order, MSB first) as seen through the input buffer.
- sf_e  out  1  StrataFlash disable / LCD select. Constant 1.
- e  out  1  LCD enable strobe.
- rs  out  1  register select driven to the LCD.
- rw  out  1  read/write to the LCD. 1 = read.
- data_oe  out  1  FPGA data-pin output enable. Always 0 while the block owns the bus.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when rd_data is valid.
- rd_data  out  8  assembled byte: {upper nibble, lower nibble}.
- bf  out  1  rd_data[7], valid at done when rs_sel was 0.
- ac  out  7  rd_data[6:0], valid at done when rs_sel was 0.

Behaviour:
- Reset values (applied at the clk edge with rst=1): state=IDLE, sf_e=1, e=0, rs=0, rw=0, data_oe=0, busy=0, done=0, rd_data=8'h00. bf and ac follow rd_data.
- All outputs are registered.
- FSM states: IDLE, SETUP, PULSE_H, GAP, PULSE_L, HOLD, DONE. Each timed state loads the counter with (T_x − 1) on entry and exits when the counter reaches 0.
- IDLE: when req=1, latch rs_sel into rs, set rw=1 and busy=1, go to SETUP. When req=0, stay in IDLE.
- SETUP: e=0 for T_AS cycles, then go to PULSE_H.
- PULSE_H: e=1 for T_PW cycles. On the last cycle, capture rd_data[7:4] <= d_in. Then go to GAP.
- GAP: e=0 for T_GAP cycles, then go to PULSE_L.
- PULSE_L: e=1 for T_PW cycles. On the last cycle, capture rd_data[3:0] <= d_in. Then go to HOLD.
- HOLD: e=0 and rw=1 for T_HOLD cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, rw returns to 0, busy returns to 0, rs returns to 0. Next state is IDLE.
- Latency: done is high exactly LAT = T_AS + 2·T_PW + T_GAP + T_HOLD + 1 rising edges after the edge that sampled req (defaults: 79).
- Earliest next accept is the cycle after DONE, so back-to-back requests are separated by one IDLE cycle.
- req held high continuously starts a new transaction each time IDLE is reached.
- req or rs_sel changes while busy=1 are ignored. rs stays constant for the whole transaction.
- rd_data holds its value from the done pulse until the next upper-nibble capture.
- Between the two captures, the upper half may show the new nibble while the lower half is stale. Consumers read rd_data only at done.
- e never rises while rw=0. rs/rw never change while e=1.
- rst during any state: next cycle all outputs return to reset values (e falls immediately) and no done is issued. A transaction is not resumed after reset.
- rst and req high together: reset wins.

Test Plan:
- rst held 3 cycles then released, req=0 for 20 cycles -> e=0, rw=0, busy=0, done=0, sf_e=1, data_oe=0 throughout.
- req pulse with rs_sel=0; LCD model drives d_in=4'hA during the first E pulse and 4'h5 during the second -> done exactly 79 edges later; rd_data=8'hA5, bf=1, ac=7'h25. Check e high for exactly 12 cycles twice, separated by 50 low cycles.
- req with rs_sel=1; d_in=4'h4 then 4'h1 -> rs=1 for the whole busy window, rd_data=8'h41 ('A'). d_in glitching to 4'hF except on the sample cycles does not change the result.
- req held high for 200 cycles -> two complete transactions, done pulses 80 cycles apart, single-cycle busy=0 gap between them, rs_sel toggled mid-transaction has no effect.
- rst asserted in cycle 30 (during GAP) -> e=0, rw=0, busy=0 on the next cycle, no done pulse. A subsequent req completes normally in 79 cycles.
- Override T_GAP=3, T_PW=2 -> LAT = 2+4+3+2+1 = 12 cycles, both nibbles captured correctly.
